// File: rtl/lsu_dmem_port.sv
// rtl/lsu_dmem_port.sv - load/store unit driving the banked data memory port
//
// Purpose:
//   Accepts one load/store request at a time from the execute stage and runs
//   it against the data memory. It drives the word address, byte-lane write
//   enables and lane-replicated write data. For loads it extracts and
//   sign/zero-extends the addressed lane. Misaligned, out-of-range and
//   illegal-funct3 requests are rejected without a memory cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_store             1 = store, 0 = load
//   req_funct3            RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr, req_wdata   byte address, store data
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  extended load data (0 for stores/errors), reject flag
//   daddr, dwdata, dwe    memory word address, write data, byte enables
//   drdata                memory read data, combinational from daddr

module lsu_dmem_port #(
    parameter logic [31:0] ADDR_LIMIT = 32'd16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] daddr_q;
    logic [31:0] dwdata_q;
    logic [3:0]  dwe_q;

    // Only the fields the ACCESS cycle still needs are kept; address and
    // write data are already folded into daddr_q/dwdata_q at acceptance.
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    // ------------------------------------------------------------------
    // Request classification, from the live request inputs
    // ------------------------------------------------------------------
    logic        req_err_d;
    logic        f3_bad;
    logic        misaligned;
    logic        out_of_range;

    always_comb begin
        f3_bad       = 1'b0;
        misaligned   = 1'b0;
        out_of_range = (req_addr >= ADDR_LIMIT);
        if (req_store) begin
            f3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            f3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
        end
        // funct3[1:0] encodes size for both loads and stores
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_err_d = f3_bad || misaligned || out_of_range;
    end

    // ------------------------------------------------------------------
    // Store lane enables and replicated data
    // ------------------------------------------------------------------
    logic [3:0]  st_dwe_d;
    logic [31:0] st_dwdata_d;

    always_comb begin
        st_dwe_d    = 4'b0000;
        st_dwdata_d = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_dwe_d    = 4'b0001 << req_addr[1:0];
                st_dwdata_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_dwe_d    = 4'b0011 << {req_addr[1], 1'b0};
                st_dwdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
                st_dwe_d    = 4'b1111;
                st_dwdata_d = req_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction and extension, from the latched request
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data_d;

    always_comb begin
        ld_byte   = drdata[8*addr_lo_q +: 8];
        ld_half   = drdata[16*addr_lo_q[1] +: 16];
        ld_data_d = drdata;
        case (funct3_q)
            3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data_d = {24'h0, ld_byte};
            3'b101:  ld_data_d = {16'h0, ld_half};
            default: ld_data_d = drdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            daddr_q      <= 32'h0;
            dwdata_q     <= 32'h0;
            dwe_q        <= 4'b0000;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        store_q     <= req_store;
                        funct3_q    <= req_funct3;
                        addr_lo_q   <= req_addr[1:0];
                        req_ready_q <= 1'b0;
                        if (req_err_d) begin
                            // Rejected: straight to RESP, daddr/dwdata untouched
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            state_q      <= S_RESP;
                        end else begin
                            daddr_q <= {req_addr[31:2], 2'b00};
                            if (req_store) begin
                                dwdata_q <= st_dwdata_d;
                                dwe_q    <= st_dwe_d;
                            end
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    dwe_q        <= 4'b0000;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= store_q ? 32'h0 : ld_data_d;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    dwe_q        <= 4'b0000;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign daddr      = daddr_q;
    assign dwdata     = dwdata_q;
    // Reset gates the enables combinationally so a store caught by reset
    // in its ACCESS cycle never reaches memory.
    assign dwe        = reset ? 4'b0000 : dwe_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// tb/tb_lsu_dmem_port.sv - directed self-checking bench for lsu_dmem_port

module tb_lsu_dmem_port;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    int checks;
    int failures;

    logic [31:0] mem [0:4095];
    logic [31:0] held_rdata;

    lsu_dmem_port dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dwe        (dwe),
        .drdata     (drdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane memory model
    assign drdata = mem[daddr[13:2]];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dwe[i]) mem[daddr[13:2]][8*i +: 8] <= dwdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with checks at each cycle of its timeline
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [3:0] exp_dwe,
                          input logic [31:0] exp_dwdata, input logic [31:0] exp_rdata);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid = 1'b0;
        if (!exp_err) begin
            chk({tag, ".acc_req_ready"}, {31'h0, req_ready}, 32'h0);
            chk({tag, ".acc_resp_valid"}, {31'h0, resp_valid}, 32'h0);
            chk({tag, ".acc_daddr"}, daddr, {addr[31:2], 2'b00});
            chk({tag, ".acc_dwe"}, {28'h0, dwe}, {28'h0, exp_dwe});
            if (st) chk({tag, ".acc_dwdata"}, dwdata, exp_dwdata);
            step();
        end else begin
            chk({tag, ".err_dwe"}, {28'h0, dwe}, 32'h0);
        end
        chk({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, ".resp_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        chk({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".resp_req_ready"}, {31'h0, req_ready}, 32'h0);
        chk({tag, ".resp_dwe"}, {28'h0, dwe}, 32'h0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, ".done_resp_valid"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, ".done_req_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[32'h50 >> 2] = 32'hCAFEF00D;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        step();
        step();
        step();
        chk("rst.dwe_in_reset", {28'h0, dwe}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst.req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst.daddr", daddr, 32'h0);
        chk("rst.dwdata", dwdata, 32'h0);
        chk("rst.dwe", {28'h0, dwe}, 32'h0);

        // Word store/load
        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF);

        // Byte store/load
        do_req("sb21", 1'b1, 3'b000, 32'h21, 32'h000000AB, 1'b0, 4'b0010, 32'hABABABAB, 32'h0);
        do_req("lb21", 1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFFAB);
        do_req("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h000000AB);
        do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000AB00);

        // Halfword store/load
        do_req("sh32", 1'b1, 3'b001, 32'h32, 32'h00008001, 1'b0, 4'b1100, 32'h80018001, 32'h0);
        do_req("lh32", 1'b0, 3'b001, 32'h32, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFF8001);
        do_req("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h00008001);

        // Rejected accesses
        do_req("e_lh33", 1'b0, 3'b001, 32'h33, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_req("e_lw42", 1'b0, 3'b010, 32'h42, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_req("e_sw4000", 1'b1, 3'b010, 32'h4000, 32'h11111111, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_req("e_ld011", 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_req("e_st100", 1'b1, 3'b100, 32'h8, 32'h22222222, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_req("e_lwhigh", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_req("lw3ffc", 1'b0, 3'b010, 32'h3FFC, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
        // Rejected store must not have written
        do_req("lw_after_err", 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);

        // Back-pressure: response held while resp_ready is low
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        step();
        req_addr   = 32'h20;
        step();
        held_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            chk("stall.resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("stall.resp_rdata", resp_rdata, held_rdata);
            chk("stall.req_ready", {31'h0, req_ready}, 32'h0);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("stall.rel_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("stall.rel_req_ready", {31'h0, req_ready}, 32'h1);
        chk("stall.rel_rdata_hold", resp_rdata, held_rdata);
        req_valid = 1'b0;
        step();
        chk("stall.idle_resp_valid", {31'h0, resp_valid}, 32'h0);

        // Reset during the ACCESS cycle of a store
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h50;
        req_wdata  = 32'h12345678;
        step();
        req_valid = 1'b0;
        chk("rst_acc.dwe_before", {28'h0, dwe}, 32'h0000000F);
        reset = 1'b1;
        #1;
        chk("rst_acc.dwe_gated", {28'h0, dwe}, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_acc.req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_acc.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_acc.dwe", {28'h0, dwe}, 32'h0);
        do_req("lw50", 1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
